// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures the decoded instruction into the EX stage,
// applies write-back bypass and store-byte masking on capture, inserts bubbles
// for flushes and load-use hazards, and freezes on Hold.
module id_ex_register #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    // ID stage
    input  logic              Valid_ID,
    input  logic [4:0]        Rs_ID,
    input  logic [4:0]        Rt_ID,
    input  logic [4:0]        Rd_ID,
    input  logic [DATA_W-1:0] Rs_data_ID,
    input  logic [DATA_W-1:0] Rt_data_ID,
    input  logic [15:0]       Imm_ID,
    input  logic [CTRL_W-1:0] Ctrl_ID,
    // write-back port
    input  logic              RegWrite_WB,
    input  logic [4:0]        RegWr_WB,
    input  logic [DATA_W-1:0] Write_data_WB,
    input  logic              Load_Byte_WB,
    // pipeline control
    input  logic              Hold,
    input  logic              Flush,
    // EX stage
    output logic              Valid_EX,
    output logic [4:0]        Rs_EX,
    output logic [4:0]        Rt_EX,
    output logic [4:0]        Rd_EX,
    output logic [DATA_W-1:0] Rs_data_EX,
    output logic [DATA_W-1:0] Rt_data_EX,
    output logic [15:0]       Imm_EX,
    output logic [CTRL_W-1:0] Ctrl_EX,
    output logic [4:0]        RegWr_EX,
    output logic              Stall_ID
);

    // Control bundle layout, MSB first:
    // {ALUOp[3:0], ALUSrc, RegDst, MemRead, MemWrite, RegWrite, MemToReg, Load_Byte, Store_Byte}
    localparam int unsigned REGDST_BIT     = CTRL_W - 6;
    localparam int unsigned MEMREAD_BIT    = CTRL_W - 7;
    localparam int unsigned STORE_BYTE_BIT = 0;
    localparam int unsigned BYTE_W         = 8;

    logic [DATA_W-1:0] wb_value;
    logic [DATA_W-1:0] rs_sel;
    logic [DATA_W-1:0] rt_sel;
    logic [DATA_W-1:0] rt_cap;
    logic              rs_bypass;
    logic              rt_bypass;
    logic              load_use;

    // Value being written back this cycle, zero-extended for byte loads
    always_comb begin
        wb_value = Write_data_WB;
        if (Load_Byte_WB) begin
            wb_value = DATA_W'(Write_data_WB[BYTE_W-1:0]);
        end
    end

    // Forward the write-back value over a stale register-file read; r0 is never forwarded
    always_comb begin
        rs_bypass = RegWrite_WB && (RegWr_WB != 5'd0) && (RegWr_WB == Rs_ID);
        rt_bypass = RegWrite_WB && (RegWr_WB != 5'd0) && (RegWr_WB == Rt_ID);
        rs_sel    = rs_bypass ? wb_value : Rs_data_ID;
        rt_sel    = rt_bypass ? wb_value : Rt_data_ID;
        rt_cap    = rt_sel;
        if (Ctrl_ID[STORE_BYTE_BIT]) begin
            rt_cap = DATA_W'(rt_sel[BYTE_W-1:0]);
        end
    end

    // Destination of the EX instruction and load-use hazard detection
    always_comb begin
        RegWr_EX = Ctrl_EX[REGDST_BIT] ? Rd_EX : Rt_EX;
        load_use = Valid_EX && Ctrl_EX[MEMREAD_BIT] && (RegWr_EX != 5'd0) && Valid_ID &&
                   ((RegWr_EX == Rs_ID) || (RegWr_EX == Rt_ID));
        Stall_ID = Hold || load_use;
    end

    // EX registers: Hold retains, Flush or load-use inserts a bubble, otherwise capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Valid_EX   <= 1'b0;
            Rs_EX      <= '0;
            Rt_EX      <= '0;
            Rd_EX      <= '0;
            Rs_data_EX <= '0;
            Rt_data_EX <= '0;
            Imm_EX     <= '0;
            Ctrl_EX    <= '0;
        end else if (!Hold) begin
            if (Flush || load_use) begin
                Valid_EX   <= 1'b0;
                Rs_EX      <= '0;
                Rt_EX      <= '0;
                Rd_EX      <= '0;
                Rs_data_EX <= '0;
                Rt_data_EX <= '0;
                Imm_EX     <= '0;
                Ctrl_EX    <= '0;
            end else begin
                Valid_EX   <= Valid_ID;
                Rs_EX      <= Rs_ID;
                Rt_EX      <= Rt_ID;
                Rd_EX      <= Rd_ID;
                Rs_data_EX <= rs_sel;
                Rt_data_EX <= rt_cap;
                Imm_EX     <= Imm_ID;
                Ctrl_EX    <= Ctrl_ID;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: expected EX contents are queued when an ID
// instruction is driven and compared one edge later.
module tb_id_ex_register;

    logic        clk;
    logic        rst_n;
    logic        Valid_ID;
    logic [4:0]  Rs_ID, Rt_ID, Rd_ID;
    logic [31:0] Rs_data_ID, Rt_data_ID;
    logic [15:0] Imm_ID;
    logic [11:0] Ctrl_ID;
    logic        RegWrite_WB;
    logic [4:0]  RegWr_WB;
    logic [31:0] Write_data_WB;
    logic        Load_Byte_WB;
    logic        Hold, Flush;
    logic        Valid_EX;
    logic [4:0]  Rs_EX, Rt_EX, Rd_EX;
    logic [31:0] Rs_data_EX, Rt_data_EX;
    logic [15:0] Imm_EX;
    logic [11:0] Ctrl_EX;
    logic [4:0]  RegWr_EX;
    logic        Stall_ID;

    typedef struct {
        string       tag;
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd;
        logic [15:0] imm;
        logic [11:0] ctrl;
        logic [4:0]  regwr;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    id_ex_register #(.DATA_W(32), .CTRL_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .Valid_ID(Valid_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID),
        .Rs_data_ID(Rs_data_ID), .Rt_data_ID(Rt_data_ID), .Imm_ID(Imm_ID), .Ctrl_ID(Ctrl_ID),
        .RegWrite_WB(RegWrite_WB), .RegWr_WB(RegWr_WB), .Write_data_WB(Write_data_WB),
        .Load_Byte_WB(Load_Byte_WB), .Hold(Hold), .Flush(Flush),
        .Valid_EX(Valid_EX), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX),
        .Rs_data_EX(Rs_data_EX), .Rt_data_EX(Rt_data_EX), .Imm_EX(Imm_EX), .Ctrl_EX(Ctrl_EX),
        .RegWr_EX(RegWr_EX), .Stall_ID(Stall_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] rsd,
                                input logic [31:0] rtd, input logic [15:0] imm,
                                input logic [11:0] ctrl, input logic [4:0] regwr);
        exp_t e;
        e.tag = ""; e.valid = v; e.rs = rs; e.rt = rt; e.rd = rd;
        e.rsd = rsd; e.rtd = rtd; e.imm = imm; e.ctrl = ctrl; e.regwr = regwr;
        return e;
    endfunction

    task automatic compare_ex();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'(1), 64'(0));
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_valid"}, 64'(Valid_EX),   64'(e.valid));
            chk({e.tag, "_rs"},    64'(Rs_EX),      64'(e.rs));
            chk({e.tag, "_rt"},    64'(Rt_EX),      64'(e.rt));
            chk({e.tag, "_rd"},    64'(Rd_EX),      64'(e.rd));
            chk({e.tag, "_rsd"},   64'(Rs_data_EX), 64'(e.rsd));
            chk({e.tag, "_rtd"},   64'(Rt_data_EX), 64'(e.rtd));
            chk({e.tag, "_imm"},   64'(Imm_EX),     64'(e.imm));
            chk({e.tag, "_ctrl"},  64'(Ctrl_EX),    64'(e.ctrl));
            chk({e.tag, "_regwr"}, 64'(RegWr_EX),   64'(e.regwr));
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [15:0] imm, input logic [11:0] ctrl);
        Valid_ID = v; Rs_ID = rs; Rt_ID = rt; Rd_ID = rd;
        Rs_data_ID = rsd; Rt_data_ID = rtd; Imm_ID = imm; Ctrl_ID = ctrl;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d,
                          input logic lb);
        RegWrite_WB = we; RegWr_WB = a; Write_data_WB = d; Load_Byte_WB = lb;
    endtask

    // Called just after a falling edge with inputs applied
    task automatic step(input string tag, input logic exp_stall, input exp_t e);
        #1;
        chk({tag, "_stall"}, 64'(Stall_ID), 64'(exp_stall));
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_ex();
        @(negedge clk);
    endtask

    initial begin
        exp_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0; Hold = 1'b0; Flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0, 0);

        // reset state and Stall_ID in reset
        #2;
        z.tag = "reset"; sb.push_back(z); compare_ex();
        Hold = 1'b1; #1 chk("rst_hold_stall", 64'(Stall_ID), 64'(1));
        Hold = 1'b0; #1 chk("rst_nohold_stall", 64'(Stall_ID), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // plain capture
        set_id(1, 8, 3, 4, 32'h00000A12, 32'h55, 16'h1234, 12'h080);
        step("capture", 0, mk(1, 8, 3, 4, 32'h00000A12, 32'h55, 16'h1234, 12'h080, 3));
        // byte-load bypass on Rt, RegDst selects Rd
        set_id(1, 5, 19, 7, 32'h11, 32'h0, 16'h00F0, 12'h040);
        set_wb(1, 19, 32'h000FFFFF, 1);
        step("byp_lb", 0, mk(1, 5, 19, 7, 32'h11, 32'hFF, 16'h00F0, 12'h040, 7));
        // WB to r0: no bypass, including for Rs_ID=0
        set_id(1, 0, 19, 7, 32'h22, 32'h0, 16'h00F0, 12'h040);
        set_wb(1, 0, 32'h000FFFFF, 1);
        step("byp_r0", 0, mk(1, 0, 19, 7, 32'h22, 32'h0, 16'h00F0, 12'h040, 7));
        // full-word bypass to both sources
        set_id(1, 9, 9, 2, 32'h1, 32'h2, 16'h0ABC, 12'h000);
        set_wb(1, 9, 32'hDEADBEEF, 0);
        step("byp_both", 0, mk(1, 9, 9, 2, 32'hDEADBEEF, 32'hDEADBEEF, 16'h0ABC, 12'h000, 9));
        // RegWrite_WB low: no bypass
        set_wb(0, 9, 32'hDEADBEEF, 0);
        step("byp_off", 0, mk(1, 9, 9, 2, 32'h1, 32'h2, 16'h0ABC, 12'h000, 9));
        // store byte
        set_id(1, 4, 10, 0, 32'h5, 32'h12345678, 16'h0001, 12'h001);
        set_wb(0, 0, 0, 0);
        step("sb", 0, mk(1, 4, 10, 0, 32'h5, 32'h78, 16'h0001, 12'h001, 10));
        // store byte of bypassed value
        set_id(1, 4, 11, 0, 32'h5, 32'h0, 16'h0001, 12'h001);
        set_wb(1, 11, 32'hCAFEBABE, 0);
        step("sb_byp", 0, mk(1, 4, 11, 0, 32'h5, 32'hBE, 16'h0001, 12'h001, 11));
        // load into EX, then dependent instruction on Rs
        set_wb(0, 0, 0, 0);
        set_id(1, 2, 8, 0, 32'h100, 32'h0, 16'h0004, 12'h0A8);
        step("lw", 0, mk(1, 2, 8, 0, 32'h100, 32'h0, 16'h0004, 12'h0A8, 8));
        set_id(1, 8, 1, 12, 32'h33, 32'h44, 16'h0010, 12'h040);
        step("lu_bubble", 1, z);
        step("lu_capture", 0, mk(1, 8, 1, 12, 32'h33, 32'h44, 16'h0010, 12'h040, 12));
        // Hold beats Flush; held data not refreshed from WB
        Hold = 1'b1; Flush = 1'b1;
        set_id(1, 7, 7, 7, 32'h99, 32'h99, 16'h0077, 12'h0A8);
        set_wb(1, 8, 32'hFFFF0000, 0);
        step("hold_flush", 1, mk(1, 8, 1, 12, 32'h33, 32'h44, 16'h0010, 12'h040, 12));
        // Flush together with load-use: bubble, stall that cycle only
        Hold = 1'b0; Flush = 1'b0;
        set_wb(0, 0, 0, 0);
        set_id(1, 1, 6, 0, 32'h61, 32'h62, 16'h0006, 12'h0A8);
        step("lw2", 0, mk(1, 1, 6, 0, 32'h61, 32'h62, 16'h0006, 12'h0A8, 6));
        Flush = 1'b1;
        set_id(1, 2, 6, 3, 32'h71, 32'h72, 16'h0007, 12'h040);
        step("flush_lu", 1, z);
        Flush = 1'b0;
        step("after_flush", 0, mk(1, 2, 6, 3, 32'h71, 32'h72, 16'h0007, 12'h040, 3));
        // invalid load captured: Valid_EX=0, no hazard afterwards
        set_id(0, 5, 3, 0, 32'h81, 32'h82, 16'h0008, 12'h0A8);
        step("inv_lw", 0, mk(0, 5, 3, 0, 32'h81, 32'h82, 16'h0008, 12'h0A8, 3));
        set_id(1, 3, 14, 0, 32'h91, 32'h92, 16'h0009, 12'h0A8);
        step("inv_ex_nohaz", 0, mk(1, 3, 14, 0, 32'h91, 32'h92, 16'h0009, 12'h0A8, 14));
        // invalid ID instruction ignored by hazard logic
        set_id(0, 14, 14, 0, 32'hA1, 32'hA2, 16'h000A, 12'h040);
        step("inv_id_nohaz", 0, mk(0, 14, 14, 0, 32'hA1, 32'hA2, 16'h000A, 12'h040, 0));
        // load to r0 never creates a hazard
        set_id(1, 5, 0, 0, 32'hB1, 32'hB2, 16'h000B, 12'h0A8);
        step("lw_r0", 0, mk(1, 5, 0, 0, 32'hB1, 32'hB2, 16'h000B, 12'h0A8, 0));
        set_id(1, 0, 0, 9, 32'hC1, 32'hC2, 16'h000C, 12'h000);
        step("r0_nohaz", 0, mk(1, 0, 0, 9, 32'hC1, 32'hC2, 16'h000C, 12'h000, 0));
        // load with RegDst=1, dependent on Rt
        set_id(1, 1, 21, 20, 32'hD1, 32'hD2, 16'h000D, 12'h0E8);
        step("lw_rd", 0, mk(1, 1, 21, 20, 32'hD1, 32'hD2, 16'h000D, 12'h0E8, 20));
        set_id(1, 3, 20, 5, 32'hE1, 32'hE2, 16'h000E, 12'h000);
        step("lu_rt_bubble", 1, z);
        step("lu_rt_capture", 0, mk(1, 3, 20, 5, 32'hE1, 32'hE2, 16'h000E, 12'h000, 20));

        // async reset between edges during Hold
        Hold = 1'b1;
        set_id(1, 4, 4, 4, 32'hF1, 32'hF2, 16'h000F, 12'h0A8);
        #1 chk("pre_rst_stall", 64'(Stall_ID), 64'(1));
        rst_n = 1'b0;
        #1;
        z.tag = "async_rst"; sb.push_back(z); compare_ex();
        chk("rst_hold_stall2", 64'(Stall_ID), 64'(1));
        Hold = 1'b0;
        rst_n = 1'b1;
        step("post_rst", 0, mk(1, 4, 4, 4, 32'hF1, 32'hF2, 16'h000F, 12'h0A8, 4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
